// File: rtl/cam_pkg.sv
// Shared types, constants and helpers for the writable tag CAM.
// NAME_TABLE holds the legacy name words loaded at reset when CAM_PRELOAD_EN is defined.
package cam_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   typedef struct packed {
      logic        vld;
      logic [3:0]  len;
      logic [63:0] data;
   } cam_entry_t;

   // {len, data}; ASCII with the first character in the least-significant byte
   localparam logic [67:0] NAME_TABLE [8] = '{
      {4'd3, 64'h00000000004F454C},   // LEO
      {4'd5, 64'h0000004E4F524141},   // AARON
      {4'd5, 64'h000000594C4C4F48},   // HOLLY
      {4'd5, 64'h0000004449564144},   // DAVID
      {4'd6, 64'h0000455249414C43},   // CLAIRE
      {4'd5, 64'h0000004B4E415246},   // FRANK
      {4'd5, 64'h00000045434E414C},   // LANCE
      {4'd4, 64'h000000004E415952}    // RYAN
   };

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: index of the lowest set bit (0 when none),
// plus any-set and more-than-one-set flags.
module cam_prio_enc
   import cam_pkg::*;
#(
   parameter  int N  = 8,
   localparam int AW = clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic [AW-1:0] o_idx,
   output logic          o_any,
   output logic          o_multi
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (i_vec[i]) o_idx = AW'(i);
   end

   assign o_any   = |i_vec;
   // clearing the lowest set bit leaves something only if two or more were set
   assign o_multi = |(i_vec & (i_vec - N'(1)));

endmodule

// File: rtl/cam_rw.sv
// Writable {len,data} CAM with a registered lowest-index search and occupancy status.
// Optional macro CAM_PRELOAD_EN: reset loads entries 0..7 with the legacy name table.
module cam_rw
   import cam_pkg::*;
#(
   parameter  int ENTRIES = 8,
   parameter  int DATA_W  = 64,
   parameter  int LEN_W   = 4,
   localparam int AW      = clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic              inv_en,
   input  logic [AW-1:0]     inv_addr,
   input  logic              srch_en,
   input  logic [DATA_W-1:0] srch_data,
   input  logic [LEN_W-1:0]  srch_len,
   output logic              res_valid,
   output logic              res_hit,
   output logic [AW-1:0]     res_addr,
   output logic              res_multi,
   output logic              full,
   output logic [AW-1:0]     free_addr
);

`ifdef CAM_PRELOAD_EN
   if (ENTRIES < 8) begin : g_preload_too_small
      $error("cam_rw: CAM_PRELOAD_EN needs ENTRIES >= 8");
   end
`endif

   logic [ENTRIES-1:0] r_vld;
   logic [LEN_W-1:0]   r_len  [ENTRIES];
   logic [DATA_W-1:0]  r_data [ENTRIES];

   logic [ENTRIES-1:0] w_match;
   logic [AW-1:0]      w_match_idx;
   logic               w_match_any;
   logic               w_match_multi;
   logic               w_free_any;
   logic               w_free_multi;

   always_comb begin
      for (int i = 0; i < ENTRIES; i++)
         w_match[i] = r_vld[i] && ({r_len[i], r_data[i]} == {srch_len, srch_data});
   end

   cam_prio_enc #(.N(ENTRIES)) u_match_enc (
      .i_vec   (w_match),
      .o_idx   (w_match_idx),
      .o_any   (w_match_any),
      .o_multi (w_match_multi)
   );

   cam_prio_enc #(.N(ENTRIES)) u_free_enc (
      .i_vec   (~r_vld),
      .o_idx   (free_addr),
      .o_any   (w_free_any),
      .o_multi (w_free_multi)
   );

   // multi implies any, so this is simply "no invalid entry left"
   assign full = ~(w_free_any | w_free_multi);

   // write is applied after invalidate so it wins on an address collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_vld[i]  <= 1'b0;
            r_len[i]  <= '0;
            r_data[i] <= '0;
         end
`ifdef CAM_PRELOAD_EN
         for (int i = 0; i < 8; i++) begin
            r_vld[i]  <= 1'b1;
            r_len[i]  <= LEN_W'(NAME_TABLE[i][67:64]);
            r_data[i] <= DATA_W'(NAME_TABLE[i][63:0]);
         end
`endif
      end else begin
         if (inv_en) r_vld[inv_addr] <= 1'b0;
         if (wr_en) begin
            r_vld[wr_addr]  <= 1'b1;
            r_len[wr_addr]  <= wr_len;
            r_data[wr_addr] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_hit   <= 1'b0;
         res_addr  <= '0;
         res_multi <= 1'b0;
      end else begin
         res_valid <= srch_en;
         if (srch_en) begin
            res_hit   <= w_match_any;
            res_addr  <= w_match_idx;
            res_multi <= w_match_multi;
         end
      end
   end

endmodule

// File: tb/tb_cam_rw.sv
// Self-checking bench for cam_rw: directed plan plus random traffic against a
// table-level model of the CAM.
module tb_cam_rw;
   localparam int ENTRIES = 8;
   localparam int AW      = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, inv_en, srch_en;
   logic [AW-1:0] wr_addr, inv_addr;
   logic [63:0] wr_data, srch_data;
   logic [3:0]  wr_len, srch_len;
   logic        res_valid, res_hit, res_multi, full;
   logic [AW-1:0] res_addr, free_addr;

   cam_rw #(.ENTRIES(ENTRIES), .DATA_W(64), .LEN_W(4)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len),
      .inv_en(inv_en), .inv_addr(inv_addr),
      .srch_en(srch_en), .srch_data(srch_data), .srch_len(srch_len),
      .res_valid(res_valid), .res_hit(res_hit), .res_addr(res_addr),
      .res_multi(res_multi), .full(full), .free_addr(free_addr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   bit         m_vld  [ENTRIES];
   logic [3:0] m_len  [ENTRIES];
   logic [63:0] m_data [ENTRIES];
   bit e_valid, e_hit, e_multi;
   int e_addr;

   function automatic logic [63:0] pk(input string s);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      string names[8] = '{"LEO","AARON","HOLLY","DAVID","CLAIRE","FRANK","LANCE","RYAN"};
      for (int i = 0; i < ENTRIES; i++) begin
         m_vld[i] = 0; m_len[i] = '0; m_data[i] = '0;
      end
`ifdef CAM_PRELOAD_EN
      for (int i = 0; i < 8; i++) begin
         m_vld[i] = 1; m_len[i] = 4'(names[i].len()); m_data[i] = pk(names[i]);
      end
`else
      if (names[0].len() == 0) $display("empty name table");
`endif
      e_valid = 0; e_hit = 0; e_multi = 0; e_addr = 0;
   endtask

   task automatic idle();
      wr_en = 0; inv_en = 0; srch_en = 0;
      wr_addr = '0; inv_addr = '0; wr_data = '0; wr_len = '0;
      srch_data = '0; srch_len = '0;
   endtask

   task automatic compare();
      int nfree;
      bit all;
      nfree = 0; all = 1;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!m_vld[i]) begin nfree = i; all = 0; end
      chk("res_valid", 64'(res_valid), 64'(e_valid));
      chk("res_hit",   64'(res_hit),   64'(e_hit));
      chk("res_addr",  64'(res_addr),  64'(e_addr));
      chk("res_multi", 64'(res_multi), 64'(e_multi));
      chk("full",      64'(full),      64'(all));
      chk("free_addr", 64'(free_addr), 64'(nfree));
   endtask

   // one clock: predict from pre-edge table, update table, check post-edge outputs
   task automatic step();
      int hits, first;
      hits = 0; first = 0;
      if (srch_en) begin
         for (int i = 0; i < ENTRIES; i++)
            if (m_vld[i] && m_len[i] == srch_len && m_data[i] == srch_data) begin
               if (hits == 0) first = i;
               hits++;
            end
         e_hit = hits > 0; e_addr = first; e_multi = hits > 1;
      end
      e_valid = srch_en;
      @(posedge clk);
      if (inv_en) m_vld[inv_addr] = 0;
      if (wr_en) begin
         m_vld[wr_addr] = 1; m_len[wr_addr] = wr_len; m_data[wr_addr] = wr_data;
      end
      #1;
      compare();
      idle();
   endtask

   task automatic wr(input int a, input string s);
      wr_en = 1; wr_addr = AW'(a); wr_len = 4'(s.len()); wr_data = pk(s);
   endtask

   task automatic srch(input int l, input string s);
      srch_en = 1; srch_len = 4'(l); srch_data = pk(s);
   endtask

   task automatic clear_all();
      for (int a = 0; a < ENTRIES; a++) begin
         inv_en = 1; inv_addr = AW'(a); step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      string pool[4] = '{"LEO","RYAN","FRANK","CLAIRE"};
      idle();
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare();
      chk("rst_res_valid", 64'(res_valid), 0);
`ifdef CAM_PRELOAD_EN
      chk("rst_full", 64'(full), 1);
`else
      chk("rst_full", 64'(full), 0);
`endif
      chk("rst_free", 64'(free_addr), 0);
      @(negedge clk);
      rst = 0;

      srch(5, "AARON"); step();
      chk("first_valid", 64'(res_valid), 1);
`ifdef CAM_PRELOAD_EN
      chk("first_hit", 64'(res_hit), 1);
      chk("first_addr", 64'(res_addr), 1);
`else
      chk("first_hit", 64'(res_hit), 0);
      chk("first_addr", 64'(res_addr), 0);
`endif
      clear_all();

      // length disambiguation
      wr(2, "LEO"); step();
      srch(4, "LEO"); step();
      chk("len4_hit", 64'(res_hit), 0);
      srch(3, "LEO"); step();
      chk("len3_hit", 64'(res_hit), 1);
      chk("len3_addr", 64'(res_addr), 2);

      // duplicates: lowest index wins, multi flagged
      wr(6, "RYAN"); step();
      wr(3, "RYAN"); step();
      srch(4, "RYAN"); step();
      chk("dup_addr", 64'(res_addr), 3);
      chk("dup_multi", 64'(res_multi), 1);
      inv_en = 1; inv_addr = 3; step();
      srch(4, "RYAN"); step();
      chk("inv_addr", 64'(res_addr), 6);
      chk("inv_multi", 64'(res_multi), 0);

      // search sees pre-edge contents
      wr(5, "FRANK"); srch(5, "FRANK"); step();
      chk("same_cyc_hit", 64'(res_hit), 0);
      srch(5, "FRANK"); step();
      chk("next_cyc_hit", 64'(res_hit), 1);
      chk("next_cyc_addr", 64'(res_addr), 5);

      // fill and occupancy
      clear_all();
      for (int i = 0; i < ENTRIES; i++) begin
         wr(i, pool[i % 4]); step();
         chk("fill_free", 64'(free_addr), 64'((i + 1) % ENTRIES));
         chk("fill_full", 64'(full), 64'(i == ENTRIES - 1));
      end
      wr(4, "LANCE"); inv_en = 1; inv_addr = 4; step();
      chk("wr_inv_full", 64'(full), 1);
      inv_en = 1; inv_addr = 4; step();
      chk("inv4_full", 64'(full), 0);
      chk("inv4_free", 64'(free_addr), 4);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            wr_en = 1; wr_addr = AW'($urandom_range(0, ENTRIES - 1));
            wr_len = 4'($urandom_range(3, 6)); wr_data = pk(pool[$urandom_range(0, 3)]);
         end
         if ($urandom_range(0, 3) == 0) begin
            inv_en = 1; inv_addr = AW'($urandom_range(0, ENTRIES - 1));
         end
         if ($urandom_range(0, 3) != 0) begin
            srch_en = 1; srch_len = 4'($urandom_range(3, 6));
            srch_data = pk(pool[$urandom_range(0, 3)]);
         end
         step();
      end

      // async reset in the middle of back-to-back searches
      srch(4, "RYAN"); step();
      srch(4, "RYAN");
      #2 rst = 1;
      #1;
      chk("arst_valid", 64'(res_valid), 0);
      chk("arst_hit", 64'(res_hit), 0);
      chk("arst_addr", 64'(res_addr), 0);
      chk("arst_multi", 64'(res_multi), 0);
      model_reset();
      @(posedge clk); #1;
      compare();
      @(negedge clk);
      rst = 0; idle();
      step();
      chk("post_rst_valid", 64'(res_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
